bch_dec_out_buffer: RTL and testbench

//  Parametrised output stage of the BCH decoder, replacing the fixed 1-bit, 2-bank out_buffer/bch_decision pair.

---
 rtl/bch_dec_out_buffer.sv | 232 +++++++++++++++++++++++
 tb/tb_bch_dec_out_buffer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_dec_out_buffer.sv
// bch_dec_out_buffer
//   Output stage of the BCH decoder. Chien-search words (corrected and uncorrected)
//   are written into a ring of 2^pBNUM_W frame banks. Each committed frame is replayed
//   as sop/val/eop words with downstream backpressure. A frame that failed to decode
//   is replayed from the uncorrected copy unless pFAIL_FIXED is set.
//
// Ports
//   iclk, ireset          clock, asynchronous active-high reset
//   iclkena               global clock enable; 0 freezes all state
//   iwrite/iwaddr         word write strobe and word address inside the frame
//   iwdat/iwdat_nfixed    corrected / uncorrected word
//   ieof                  with iwrite: last word, commits the frame
//   idecfail/ibiterr      frame status, sampled with the committing write
//   ofull                 every bank holds a frame not yet fully read out
//   oovf                  sticky: a write was attempted while ofull
//   ireq                  downstream ready
//   osop/oval/oeop/oeof   output framing, transfer on oval & ireq
//   odat                  output word
//   odecfail/obiterr      status of the frame being replayed
module bch_dec_out_buffer #(
  parameter int unsigned m           = 4,
  parameter int unsigned pLEN        = 15,
  parameter int unsigned pDAT_W      = 1,
  parameter int unsigned pBNUM_W     = 1,
  parameter int unsigned pFAIL_FIXED = 0
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  input  logic              iwrite,
  input  logic [m-1:0]      iwaddr,
  input  logic [pDAT_W-1:0] iwdat,
  input  logic [pDAT_W-1:0] iwdat_nfixed,
  input  logic              ieof,
  input  logic              idecfail,
  input  logic [m-1:0]      ibiterr,
  output logic              ofull,
  output logic              oovf,
  input  logic              ireq,
  output logic              osop,
  output logic              oval,
  output logic              oeop,
  output logic              oeof,
  output logic [pDAT_W-1:0] odat,
  output logic              odecfail,
  output logic [m-1:0]      obiterr
);

  localparam int unsigned NBanks    = 2 ** pBNUM_W;
  localparam int unsigned NWords    = 2 ** m;
  localparam int unsigned UsedW     = pBNUM_W + 1;
  localparam logic [m-1:0] LastAddr = m'(pLEN - 1);
  localparam logic [UsedW-1:0] UsedFull = UsedW'(NBanks);
  localparam logic FailFixed = (pFAIL_FIXED != 0);

  typedef enum logic [1:0] {StIdle, StRead, StLast} state_e;

  // {nfixed, fixed} per word
  logic [2*pDAT_W-1:0] mem_q [NBanks][NWords];
  logic                side_dec_q [NBanks];
  logic [m-1:0]        side_bit_q [NBanks];

  state_e               state_q, state_d;
  logic [m-1:0]         raddr_q, raddr_d;
  logic [pBNUM_W-1:0]   wptr_q, wptr_d;
  logic [pBNUM_W-1:0]   rptr_q, rptr_d;
  logic [UsedW-1:0]     used_q, used_d;
  logic                 ofull_q, ofull_d;
  logic                 oovf_q, oovf_d;
  logic                 oval_q, oval_d;
  logic                 osop_q, osop_d;
  logic                 oeop_q, oeop_d;
  logic [pDAT_W-1:0]    odat_q, odat_d;
  logic                 odecfail_q, odecfail_d;
  logic [m-1:0]         obiterr_q, obiterr_d;

  logic                 wr_en, commit, release_bank, pipe_en, issue;
  logic [pBNUM_W-1:0]   rd_bank;
  logic [m-1:0]         rd_addr;
  logic [2*pDAT_W-1:0]  rd_word;
  logic                 rd_dec;

  assign wr_en        = iclkena & iwrite & ~ofull_q;
  assign commit       = wr_en & ieof;
  assign release_bank = iclkena & oval_q & oeop_q & ireq;
  // Output register advances when empty or when its word is being taken.
  assign pipe_en      = iclkena & (ireq | ~oval_q);

  always_ff @(posedge iclk) begin
    if (wr_en) begin
      mem_q[wptr_q][iwaddr] <= {iwdat_nfixed, iwdat};
    end
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      for (int i = 0; i < int'(NBanks); i++) begin
        side_dec_q[i] <= 1'b0;
        side_bit_q[i] <= '0;
      end
    end else if (commit) begin
      side_dec_q[wptr_q] <= idecfail;
      side_bit_q[wptr_q] <= ibiterr;
    end
  end

  // Read sequencer. On the last-word transfer the next frame's word 0 is issued in the
  // same cycle so consecutive frames stream without a bubble.
  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    rptr_d  = rptr_q;
    issue   = 1'b0;
    rd_bank = rptr_q;
    rd_addr = raddr_q;
    unique case (state_q)
      StIdle: begin
        if (pipe_en && used_q != '0) begin
          state_d = StRead;
          raddr_d = '0;
        end
      end
      StRead: begin
        if (pipe_en) begin
          issue = 1'b1;
          if (raddr_q == LastAddr) begin
            state_d = StLast;
          end else begin
            raddr_d = raddr_q + m'(1);
          end
        end
      end
      StLast: begin
        if (release_bank) begin
          rptr_d = rptr_q + pBNUM_W'(1);
          if (used_q > UsedW'(1)) begin
            issue   = 1'b1;
            rd_bank = rptr_q + pBNUM_W'(1);
            rd_addr = '0;
            if (LastAddr == '0) begin
              state_d = StLast;
            end else begin
              state_d = StRead;
              raddr_d = m'(1);
            end
          end else begin
            state_d = StIdle;
            raddr_d = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign rd_word = mem_q[rd_bank][rd_addr];
  assign rd_dec  = side_dec_q[rd_bank];

  always_comb begin
    oval_d     = oval_q;
    osop_d     = osop_q;
    oeop_d     = oeop_q;
    odat_d     = odat_q;
    odecfail_d = odecfail_q;
    obiterr_d  = obiterr_q;
    if (pipe_en) begin
      oval_d = issue;
      osop_d = issue && (rd_addr == '0);
      oeop_d = issue && (rd_addr == LastAddr);
      if (issue) begin
        odat_d     = (rd_dec & ~FailFixed) ? rd_word[2*pDAT_W-1:pDAT_W] : rd_word[pDAT_W-1:0];
        odecfail_d = rd_dec;
        obiterr_d  = side_bit_q[rd_bank];
      end
    end
  end

  always_comb begin
    used_d = used_q;
    if (commit && !release_bank) begin
      used_d = used_q + UsedW'(1);
    end else if (!commit && release_bank) begin
      used_d = used_q - UsedW'(1);
    end
    wptr_d  = commit ? wptr_q + pBNUM_W'(1) : wptr_q;
    ofull_d = (used_d == UsedFull);
    oovf_d  = oovf_q | (iclkena & iwrite & ofull_q);
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q    <= StIdle;
      raddr_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      used_q     <= '0;
      ofull_q    <= 1'b0;
      oovf_q     <= 1'b0;
      oval_q     <= 1'b0;
      osop_q     <= 1'b0;
      oeop_q     <= 1'b0;
      odat_q     <= '0;
      odecfail_q <= 1'b0;
      obiterr_q  <= '0;
    end else begin
      state_q    <= state_d;
      raddr_q    <= raddr_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      used_q     <= used_d;
      ofull_q    <= ofull_d;
      oovf_q     <= oovf_d;
      oval_q     <= oval_d;
      osop_q     <= osop_d;
      oeop_q     <= oeop_d;
      odat_q     <= odat_d;
      odecfail_q <= odecfail_d;
      obiterr_q  <= obiterr_d;
    end
  end

  assign ofull    = ofull_q;
  assign oovf     = oovf_q;
  assign oval     = oval_q;
  assign osop     = osop_q;
  assign oeop     = oeop_q;
  assign oeof     = oeop_q;
  assign odat     = odat_q;
  assign odecfail = odecfail_q;
  assign obiterr  = obiterr_q;

endmodule

// File: tb/tb_bch_dec_out_buffer.sv
// Scoreboard bench for bch_dec_out_buffer (8-bit words, 4 banks, 15-word frames).
module tb_bch_dec_out_buffer;

  localparam int unsigned M   = 4;
  localparam int unsigned LEN = 15;
  localparam int unsigned DW  = 8;
  localparam int unsigned BW  = 2;
  localparam int          NB  = 4;

  logic          iclk = 1'b0;
  logic          ireset = 1'b1;
  logic          iclkena = 1'b0;
  logic          iwrite = 1'b0;
  logic [M-1:0]  iwaddr = '0;
  logic [DW-1:0] iwdat = '0;
  logic [DW-1:0] iwdat_nfixed = '0;
  logic          ieof = 1'b0;
  logic          idecfail = 1'b0;
  logic [M-1:0]  ibiterr = '0;
  logic          ofull, oovf;
  logic          ireq = 1'b0;
  logic          osop, oval, oeop, oeof;
  logic [DW-1:0] odat;
  logic          odecfail;
  logic [M-1:0]  obiterr;

  bch_dec_out_buffer #(
    .m(M), .pLEN(LEN), .pDAT_W(DW), .pBNUM_W(BW), .pFAIL_FIXED(0)
  ) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .iwrite(iwrite), .iwaddr(iwaddr),
    .iwdat(iwdat), .iwdat_nfixed(iwdat_nfixed), .ieof(ieof), .idecfail(idecfail),
    .ibiterr(ibiterr), .ofull(ofull), .oovf(oovf), .ireq(ireq), .osop(osop), .oval(oval),
    .oeop(oeop), .oeof(oeof), .odat(odat), .odecfail(odecfail), .obiterr(obiterr)
  );

  always #5 iclk = ~iclk;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          sop;
    logic          eop;
    logic          dec;
    logic [M-1:0]  bits;
  } exp_t;

  // Reference model: frames committed but not yet fully read out, and their words.
  exp_t          exp_q[$];
  int            model_cnt = 0;
  bit            model_ovf = 1'b0;
  logic [DW-1:0] buf_fx [LEN];
  logic [DW-1:0] buf_nf [LEN];
  int            out_idx = 0;
  int            lat = 0;
  bit            gap_exp = 1'b0;
  int            checks_total = 0;
  int            checks_pass = 0;
  int            drv_to = 0;
  bit            done = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks_total++;
    if (act === req) checks_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
  endfunction

  // Monitor: all checks and model updates on the falling edge.
  always @(negedge iclk) begin
    if (ireset) begin
      chk("reset_outputs", {oval, osop, oeop, oeof, odat, odecfail, obiterr, ofull, oovf}, 64'd0);
      exp_q.delete();
      model_cnt = 0;
      model_ovf = 1'b0;
      out_idx   = 0;
      lat       = 0;
      gap_exp   = 1'b0;
    end else begin
      automatic bit   full_pre = (model_cnt == NB);
      automatic int   cnt_pre  = model_cnt;
      automatic exp_t e;
      chk("ofull", ofull, full_pre);
      chk("oovf", oovf, model_ovf);
      if (lat == 1 || lat == 2) begin
        chk("first_latency_idle", oval, 1'b0);
        lat = iclkena ? lat + 1 : 0;
      end else if (lat == 3) begin
        chk("first_latency_val", oval, 1'b1);
        lat = 0;
      end
      if (gap_exp) chk("no_gap", oval, 1'b1);
      gap_exp = 1'b0;
      if (oval) begin
        if (exp_q.size() == 0) begin
          chk("spurious_oval", oval, 1'b0);
        end else begin
          e = exp_q[0];
          chk("word", {odat, osop, oeop, oeof}, {e.dat, e.sop, e.eop, e.eop});
          if (e.eop) chk("frame_status", {odecfail, obiterr}, {e.dec, e.bits});
          if (ireq && iclkena) begin
            void'(exp_q.pop_front());
            if (e.eop) begin
              model_cnt--;
              out_idx = 0;
              gap_exp = (cnt_pre >= 2);
            end else begin
              out_idx++;
              gap_exp = 1'b1;
            end
          end
        end
      end
      if (iclkena && iwrite) begin
        if (full_pre) begin
          model_ovf = 1'b1;
        end else if (int'(iwaddr) < int'(LEN)) begin
          buf_fx[int'(iwaddr)] = iwdat;
          buf_nf[int'(iwaddr)] = iwdat_nfixed;
          if (ieof) begin
            if (cnt_pre == 0) lat = 1;
            for (int i = 0; i < int'(LEN); i++) begin
              e.dat  = idecfail ? buf_nf[i] : buf_fx[i];
              e.sop  = (i == 0);
              e.eop  = (i == int'(LEN) - 1);
              e.dec  = idecfail;
              e.bits = ibiterr;
              exp_q.push_back(e);
            end
            model_cnt++;
          end
        end
      end
    end
    if (done) begin
      chk("driver_timeouts", drv_to, 0);
      chk("drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", checks_pass, checks_total);
      $finish;
    end
  end

  // Driver
  int req_mode = 1;  // 0: never ready, 1: always ready, 2: random
  bit ena_rand = 1'b0;
  bit gaps     = 1'b0;
  bit last_ena;

  task automatic step();
    ireq     = (req_mode == 2) ? ($urandom_range(0, 2) != 0) : (req_mode == 1);
    iclkena  = ena_rand ? ($urandom_range(0, 7) != 0) : 1'b1;
    last_ena = iclkena;
    @(posedge iclk);
    #1;
  endtask

  task automatic write_word(input int addr, input bit eof, input bit dec, input int bits);
    int guard = 0;
    iwrite       = 1'b1;
    iwaddr       = M'(addr);
    iwdat        = DW'($urandom);
    iwdat_nfixed = DW'($urandom);
    ieof         = eof;
    idecfail     = dec;
    ibiterr      = M'(bits);
    do begin
      step();
      guard++;
    end while (!last_ena && guard < 100);
    iwrite = 1'b0;
    ieof   = 1'b0;
  endtask

  task automatic write_frame(input bit dec, input int bits);
    int guard = 0;
    while (model_cnt >= NB && guard < 5000) begin
      step();
      guard++;
    end
    if (guard >= 5000) begin
      drv_to++;
      return;
    end
    for (int i = 0; i < int'(LEN); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) step();
      write_word(i, i == int'(LEN) - 1, dec, bits);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while ((model_cnt > 0 || exp_q.size() > 0) && guard < 5000) begin
      step();
      guard++;
    end
    if (guard >= 5000) drv_to++;
  endtask

  initial begin
    int guard;
    repeat (3) step();
    ireset = 1'b0;
    step();

    // Single frames, ready always high: corrected then failed frame.
    write_frame(1'b0, 2);
    drain();
    write_frame(1'b1, 5);
    drain();

    // Fill all banks with no downstream ready, then overflow with a committing write.
    req_mode = 0;
    for (int f = 0; f < NB; f++) write_frame(f[0], f);
    step();
    write_word(3, 1'b1, 1'b0, 9);
    repeat (4) step();
    req_mode = 1;
    drain();

    // Random backpressure, clock enable and write gaps.
    req_mode = 2;
    ena_rand = 1'b1;
    gaps     = 1'b1;
    for (int f = 0; f < 12; f++) write_frame($urandom_range(0, 1) == 1, $urandom_range(0, 15));
    drain();

    // Reset while word 7 of a frame is presented, then a fresh frame.
    req_mode = 1;
    ena_rand = 1'b0;
    gaps     = 1'b0;
    write_frame(1'b0, 7);
    guard = 0;
    while (out_idx != 7 && guard < 200) begin
      step();
      guard++;
    end
    if (guard >= 200) drv_to++;
    ireset = 1'b1;
    repeat (2) step();
    ireset = 1'b0;
    step();
    write_frame(1'b1, 11);
    drain();

    done = 1'b1;
    repeat (3) @(posedge iclk);
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, %0d/%0d", checks_pass,
             checks_total);
    $fatal(1);
  end

endmodule
